rf_wb_scheduler: RTL and testbench

- Schedules all writes into the single write port of the integer register file, which has 2**ADDR_WIDTH entries with x0 hardwired to zero.
- Two writeback sources share that port under round-robin arbitration with valid/ready handshakes: source 0 is the EXU (ALU results), source 1 is the LSU (load data).
- Keeps a per-register busy scoreboard, set at issue and cleared at writeback, so the decoder can stall on RAW and WAW hazards.
- Sits between EXU/LSU and the register file write port (wen/waddr/wdata).

---
 rtl/rf_wb_scheduler.sv | 118 +++++++++++
 tb/tb_rf_wb_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: round-robin EXU/LSU write port + busy scoreboard.
// Optional RF_WB_BYPASS_EN adds forwarding of the staged write to the rs queries.
module rf_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef RF_WB_BYPASS_EN
  output logic                  rs1_fwd_valid,
  output logic                  rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs_fwd_data1,
  output logic [DATA_WIDTH-1:0] rs_fwd_data2,
`endif
  input  logic                  s0_valid,
  input  logic [ADDR_WIDTH-1:0] s0_rd,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [ADDR_WIDTH-1:0] s1_rd,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  last_q, last_d;

  logic                  gnt0, gnt1, hs;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  iss_fire;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (s0_valid && s1_valid): begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end
      (s0_valid && !s1_valid): gnt0 = 1'b1;
      (!s0_valid && s1_valid): gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;
  assign hs       = gnt0 | gnt1;
  assign sel_rd   = gnt1 ? s1_rd : s0_rd;
  assign sel_data = gnt1 ? s1_data : s0_data;

  assign iss_ready = !busy_q[iss_rd] || (iss_rd == '0);
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    last_d  = hs ? gnt1 : last_q;
    wen_d   = hs && (sel_rd != '0);
    waddr_d = wen_d ? sel_rd : waddr_q;
    wdata_d = wen_d ? sel_data : wdata_q;
  end

  // Clear first so a same-edge issue to the written register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (iss_fire) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

`ifdef RF_WB_BYPASS_EN
  assign rs1_fwd_valid = wen_q && (waddr_q == rs1) && (rs1 != '0);
  assign rs2_fwd_valid = wen_q && (waddr_q == rs2) && (rs2 != '0);
  assign rs_fwd_data1  = wdata_q;
  assign rs_fwd_data2  = wdata_q;
  assign rs1_busy      = busy_q[rs1] && !rs1_fwd_valid;
  assign rs2_busy      = busy_q[rs2] && !rs2_fwd_valid;
`else
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: expected writes queued at grant,
// popped by a monitor whenever rf_wen is seen.
module tb_rf_wb_scheduler;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          iss_ready;
  logic [AW-1:0] rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic          s0_valid, s1_valid;
  logic [AW-1:0] s0_rd, s1_rd;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_ready, s1_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
  logic          rs1_fwd_valid, rs2_fwd_valid;
  logic [DW-1:0] rs_fwd_data1, rs_fwd_data2;
`endif

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rf_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef RF_WB_BYPASS_EN
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs_fwd_data1(rs_fwd_data1), .rs_fwd_data2(rs_fwd_data2),
`endif
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data),
    .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data),
    .s1_ready(s1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a writeback request; expg is the hand-derived grant (2 = none).
  task automatic req(input logic v0, input logic [AW-1:0] r0,
                     input logic [DW-1:0] d0, input logic v1,
                     input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                     input int expg);
    s0_valid = v0; s0_rd = r0; s0_data = d0;
    s1_valid = v1; s1_rd = r1; s1_data = d1;
    #1;
    chk("s0_ready", s0_ready, expg == 0);
    chk("s1_ready", s1_ready, expg == 1);
    if (expg == 0 && r0 != 0) exp_q.push_back({r0, d0});
    if (expg == 1 && r1 != 0) exp_q.push_back({r1, d1});
    step();
    s0_valid = 0;
    s1_valid = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rf_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h", rf_waddr,
                 rf_wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("rf_waddr", 64'(rf_waddr), 64'(e[AW+DW-1:DW]));
        chk("rf_wdata", 64'(rf_wdata), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t limit 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; iss_valid = 0; iss_rd = 0; rs1 = 5; rs2 = 31;
    s0_valid = 0; s0_rd = 0; s0_data = 0;
    s1_valid = 0; s1_rd = 0; s1_data = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_rs1_busy", rs1_busy, 0);
    chk("reset_rs2_busy", rs2_busy, 0);
    chk("reset_iss_ready", iss_ready, 1);
    step();

    // issue rd=3, write it back from EXU
    iss_valid = 1; iss_rd = 3;
    #1 chk("iss3_ready", iss_ready, 1);
    step();
    iss_valid = 0; rs1 = 3;
    #1 chk("rs1_busy_3", rs1_busy, 1);
    req(1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("wb3_wen", rf_wen, 1);
    chk("wb3_still_busy", rs1_busy, 1);
    step();
    chk("wb3_cleared", rs1_busy, 0);

    // WAW stall on rd=7 (last grant now 0)
    iss_valid = 1; iss_rd = 7;
    step();
    #1 chk("waw_stall_a", iss_ready, 0);
    req(0, 0, 0, 1, 7, 32'h77, 1);
    chk("waw_stall_b", iss_ready, 0);
    step();
    chk("waw_release", iss_ready, 1);
    iss_valid = 0;
    step();

    // contention: last grant is 1, so 0,1,0,1 then s0 alone
    req(1, 1, 32'hA1, 1, 2, 32'hA2, 0);
    req(1, 3, 32'hA3, 1, 2, 32'hA2, 1);
    req(1, 3, 32'hA3, 1, 4, 32'hA4, 0);
    req(1, 5, 32'hA5, 1, 4, 32'hA4, 1);
    req(1, 5, 32'hA5, 0, 0, 0, 0);
    step();

    // x0 handling
    iss_valid = 1; iss_rd = 0;
    #1 chk("x0_iss_ready", iss_ready, 1);
    step();
    iss_valid = 0; rs1 = 0; rs2 = 0;
    #1 chk("x0_rs1_busy", rs1_busy, 0);
    req(0, 0, 0, 1, 0, 32'h1234, 1);
    chk("x0_no_wen", rf_wen, 0);
    step();

    // same-edge set and clear of rd=9
    req(1, 9, 32'h99, 0, 0, 0, 0);
    iss_valid = 1; iss_rd = 9; rs1 = 9;
    #1 chk("set9_ready", iss_ready, 1);
    chk("set9_rs1_busy", rs1_busy, 0);
`ifdef RF_WB_BYPASS_EN
    chk("fwd1_valid", rs1_fwd_valid, 1);
    chk("fwd1_data", rs_fwd_data1, 32'h99);
    chk("fwd2_valid", rs2_fwd_valid, 0);
`endif
    step();
    iss_valid = 0;
    #1 chk("set9_wins", rs1_busy, 1);
    req(0, 0, 0, 1, 9, 32'h9A, 1);
`ifdef RF_WB_BYPASS_EN
    chk("fwd9_busy_masked", rs1_busy, 0);
`else
    chk("wb9_busy", rs1_busy, 1);
`endif
    step();
    chk("clr9", rs1_busy, 0);

    // async reset mid-operation drops busy and staged write
    iss_valid = 1; iss_rd = 12;
    step();
    iss_valid = 0; rs1 = 12;
    s0_valid = 1; s0_rd = 13; s0_data = 32'hBAD;
    #1 chk("pre_rst_busy12", rs1_busy, 1);
    step();
    s0_valid = 0;
    rst_n = 0;
    #1 chk("rst_wen", rf_wen, 0);
    chk("rst_busy12", rs1_busy, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    step();
    req(1, 14, 32'hE0, 1, 15, 32'hE1, 0);
    req(1, 14, 32'hE0, 1, 15, 32'hE1, 1);
    step();
    step();

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
